uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port baud_set  input  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; codes 5-7 select 9600.
REQ-005 SHALL have port rs232_rx  input  1  serial line, asynchronous, idle high.
REQ-006 SHALL have port data_byte  output  8  last correctly received byte.
REQ-007 SHALL have port rx_done  output  1  one-cycle pulse when data_byte updates.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port uart_state  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass rs232_rx through a 2-flop synchroniser, then one further flop for edge detection.
REQ-011 SHALL produce a sample tick at 16x the baud rate: divider = CLK_FREQ/(baud*16), truncated; counter runs 0..divider-1.
REQ-012 SHALL clear the tick counter while IDLE, so that the tick phase aligns to the start edge.
REQ-013 SHALL index each bit as ticks 0-15 and take that bit's value as the 2-of-3 majority of the synchronised line at ticks 6, 7 and 8.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-015 SHALL move IDLE->START on a synchronised falling edge.
REQ-016 SHALL, in START, return to IDLE if the start vote is 1 (glitch rejection, no output pulse), and otherwise go to DATA after tick 15.
REQ-017 SHALL, in DATA, shift in 8 bits LSB first into an internal shift register, then go to PARITY or STOP.
REQ-018 SHALL, in STOP, decide at tick 8 and return to IDLE on the next cycle (half a bit early for resync).
REQ-019 SHALL, on a stop vote of 1, load data_byte from the shift register and pulse rx_done for exactly one cycle, both one clk after the tick-8 decision.
REQ-020 SHALL, on a stop vote of 0, pulse frame_err for one cycle with the same timing and leave data_byte unchanged.
REQ-021 SHALL never assert rx_done and frame_err in the same cycle.
REQ-022 SHALL treat a change of baud_set during a frame as undefined for that frame, and SHALL correctly receive the next frame at the new rate.
REQ-023 SHALL accept a falling edge one clk after returning to IDLE, so back-to-back frames are received.

Reset
REQ-024 SHALL, while rst is low, force: FSM=IDLE, counters=0, synchroniser flops=1, data_byte=8'h00, rx_done=0, frame_err=0, uart_state=0, parity_err=0.
REQ-025 SHALL abandon any frame in progress on reset without issuing a pulse; after release it SHALL wait for a fresh falling edge.

Configuration
REQ-026 SHALL, with UART_RX_PARITY_EN defined, expect an even-parity bit after D7 (PARITY state), add output parity_err (1 bit, one-cycle pulse), and on mismatch pulse parity_err instead of rx_done at the stop decision, leaving data_byte unchanged.
REQ-027 SHALL, without UART_RX_PARITY_EN, operate as 8N1 with no PARITY state and no parity_err port.
REQ-028 SHALL, when frame_err and parity error coincide, pulse frame_err only.

Structure
REQ-029 SHALL place the FSM state encoding, the baud_set code constants and the 16x oversample constant in shared package uart_pkg, for reuse by the transmitter.
REQ-030 SHALL contain exactly one sub-module, uart_rx_tick_gen (divider plus baud_set lookup, clear input, tick output).

Verification
REQ-031 Bench SHALL cover at CLK_FREQ=50 MHz, baud_set=4 (divider 27): line frame 0x55 -> single rx_done, data_byte=8'h55, uart_state falls ~9.5 bit times after the start edge.
REQ-032 Bench SHALL cover a 0.2-bit low glitch on an idle line -> no rx_done, no frame_err, FSM back in IDLE before 1 bit time.
REQ-033 Bench SHALL cover frame 0xA3 with stop bit forced low -> frame_err pulse of 1 cycle, data_byte keeps its prior value 8'h55.
REQ-034 Bench SHALL cover back-to-back frames 0x00, 0xFF, 0x3C with no idle gap at baud_set=0 -> three rx_done pulses with matching values.
REQ-035 Bench SHALL cover rst driven low mid-frame at bit D4, then frame 0x81 -> no pulse for the aborted frame, then data_byte=8'h81.
REQ-036 Bench SHALL cover, with UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err pulse, no rx_done; the same frame with parity 1 -> rx_done, data_byte=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud_set codes, 16x oversample
// constant and the sample-tick divider helper, common to receiver and transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2, ST_STOP = 3'd3, ST_PARITY = 3'd4
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2, ST_STOP = 3'd3
  } rx_state_e;
`endif

  // Unused codes fall back to the slowest rate.
  function automatic int unsigned baud_rate(input logic [2:0] code);
    case (code)
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      BAUD_115200: return 115200;
      default:     return 9600;
    endcase
  endfunction

  function automatic int unsigned tick_div(input int unsigned clk_freq, input logic [2:0] code);
    int unsigned d;
    d = clk_freq / (baud_rate(code) * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversample tick generator: per-rate divider chosen by baud_set,
// held at zero while clr is high so the tick phase starts at the start edge.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic       clr,
  output logic       tick
);

  localparam int unsigned DIV_0 = tick_div(CLK_FREQ, BAUD_9600);
  localparam int unsigned DIV_1 = tick_div(CLK_FREQ, BAUD_19200);
  localparam int unsigned DIV_2 = tick_div(CLK_FREQ, BAUD_38400);
  localparam int unsigned DIV_3 = tick_div(CLK_FREQ, BAUD_57600);
  localparam int unsigned DIV_4 = tick_div(CLK_FREQ, BAUD_115200);
  localparam int CW = (DIV_0 < 2) ? 1 : $clog2(DIV_0 + 1);

  logic [CW-1:0] div_lim;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  always_comb begin
    case (baud_set)
      BAUD_19200:  div_lim = CW'(DIV_1 - 1);
      BAUD_38400:  div_lim = CW'(DIV_2 - 1);
      BAUD_57600:  div_lim = CW'(DIV_3 - 1);
      BAUD_115200: div_lim = CW'(DIV_4 - 1);
      default:     div_lim = CW'(DIV_0 - 1);
    endcase
  end

  // ">=" rather than "==" so a mid-frame rate change cannot strand the counter.
  always_comb begin
    wrap  = (cnt_q >= div_lim);
    cnt_d = cnt_q + 1'b1;
    if (clr || wrap) cnt_d = '0;
    tick  = wrap && !clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver, 8N1 with 16x oversampling and 2-of-3 majority voting.
// Define UART_RX_PARITY_EN for 8E1 with an extra parity_err pulse output.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic       rs232_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  ones_q, ones_d, ones_now;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic        rx_done_q, rx_done_d, frame_err_q, frame_err_d;
  logic        uart_state_q, uart_state_d;
  logic        tick, tick_clr, rx_fall, vote, t8, t15;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d, parity_err_q, parity_err_d;
`endif

  assign tick_clr = (state_q == ST_IDLE);

  uart_rx_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .baud_set (baud_set),
    .clr      (tick_clr),
    .tick     (tick)
  );

  always_comb begin
    sync1_d      = rs232_rx;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    shift_d      = shift_q;
    data_byte_d  = data_byte_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    rx_fall  = prev_q & ~sync2_q;
    // ones_q holds the votes from ticks 6 and 7; tick 8 adds the live sample.
    ones_now = ones_q + {1'b0, sync2_q};
    vote     = ones_now[1];
    t8       = tick && (tick_cnt_q == 4'd8);
    t15      = tick && (tick_cnt_q == 4'd15);

    if (state_q == ST_IDLE) begin
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      ones_d     = '0;
      if (rx_fall) state_d = ST_START;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      if (tick_cnt_q >= 4'd6 && tick_cnt_q <= 4'd8) ones_d = ones_now;
      if (tick_cnt_q == 4'd15) ones_d = '0;
    end

    case (state_q)
      ST_IDLE: ;
      ST_START: begin
        if (t8 && vote) state_d = ST_IDLE;
        else if (t15)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (t8) shift_d = {vote, shift_q[7:1]};
        if (t15) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (t8)  par_d   = vote;
        if (t15) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leave half a bit early so the next start edge is never missed.
        if (t8) begin
          state_d = ST_IDLE;
          if (!vote) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (^{shift_q, par_q}) parity_err_d = 1'b1;
`endif
          else begin
            rx_done_d   = 1'b1;
            data_byte_d = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    uart_state_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      shift_q      <= '0;
      data_byte_q  <= 8'h00;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      uart_state_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      shift_q      <= shift_d;
      data_byte_q  <= data_byte_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      uart_state_q <= uart_state_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_byte  = data_byte_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign uart_state = uart_state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: stimulus pushes the expected outcome of
// each frame, an independent monitor pops and checks on every output pulse.
module tb_uart_byte_rx;

  localparam int unsigned CLK_FREQ = 50_000_000;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int K_DONE = 0, K_FERR = 1, K_PERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     exp_cyc;
    longint     tol;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] baud_set;
  logic       rs232_rx;
  logic [7:0] data_byte;
  logic       rx_done, frame_err, uart_state, perr;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  assign perr = parity_err;
`else
  assign perr = 1'b0;
`endif

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_set   (baud_set),
    .rs232_rx   (rs232_rx),
    .data_byte  (data_byte),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  longint     cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       sb[$];
  logic [7:0] last_good;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         ignore_pulses;

  // Clocks per bit straight from the rate table: truncated divider times 16.
  function automatic int bit_clks(input int code);
    int baud;
    case (code)
      1: baud = 19200;
      2: baud = 38400;
      3: baud = 57600;
      4: baud = 115200;
      default: baud = 9600;
    endcase
    return (CLK_FREQ / (baud * 16)) * 16;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  // Monitor
  logic mon_pulse;
  logic prev_pulse = 1'b0;
  exp_t mon_e;
  int   mon_kind;
  always @(negedge clk) begin
    mon_pulse = rx_done | frame_err | perr;
    if (rst && mon_pulse && !ignore_pulses) begin
      check("done_ferr_exclusive", rx_done & frame_err, 0);
`ifdef UART_RX_PARITY_EN
      check("ferr_perr_exclusive", frame_err & perr, 0);
`endif
      check("pulse_one_cycle", prev_pulse, 0);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got rx_done=%0d frame_err=%0d parity_err=%0d, required none",
                 rx_done, frame_err, perr);
      end else begin
        mon_e = sb.pop_front();
        mon_kind = frame_err ? K_FERR : (perr ? K_PERR : K_DONE);
        check("pulse_kind", mon_kind, mon_e.kind);
        if (mon_e.kind == K_DONE) last_good = mon_e.data;
        check("data_byte", data_byte, last_good);
        check("uart_state_at_decision", uart_state, 0);
        check_range("decision_time", cyc, mon_e.exp_cyc - mon_e.tol, mon_e.exp_cyc + mon_e.tol);
      end
    end
    prev_pulse = mon_pulse;
  end

  task automatic drive_bit(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // par_force < 0 sends the correct even-parity bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int par_force);
    int   bc;
    logic par;
    exp_t e;
    bc  = bit_clks(int'(baud_set));
    par = ^b;
    if (par_force >= 0) par = par_force[0];
    e.data = b;
    if (!stop_bit)                  e.kind = K_FERR;
    else if (PAR_EN && par != (^b)) e.kind = K_PERR;
    else                            e.kind = K_DONE;
    // Decision lands half-way through the stop bit.
    e.exp_cyc = cyc + ((19 + 2 * PAR_EN) * bc) / 2;
    e.tol     = bc / 8;
    sb.push_back(e);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
    if (PAR_EN != 0) drive_bit(par, bc);
    drive_bit(stop_bit, bc);
  endtask

  initial begin
    int         bc;
    logic [7:0] rb, ab;
    bit         rs;
    int         pf;
    rst = 1'b0; rs232_rx = 1'b1; baud_set = 3'd4; ignore_pulses = 1'b0; last_good = 8'h00;
    repeat (5) @(negedge clk);
    check("reset_data_byte", data_byte, 8'h00);
    check("reset_rx_done", rx_done, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_uart_state", uart_state, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    bc = bit_clks(4);
    send_frame(8'h55, 1'b1, -1);
    drive_bit(1'b1, bc);

    // 0.2-bit glitch must be rejected within one bit time
    rs232_rx = 1'b0;
    repeat (bc / 5) @(negedge clk);
    check("glitch_enters_start", uart_state, 1);
    rs232_rx = 1'b1;
    repeat (bc - bc / 5) @(negedge clk);
    check("glitch_back_idle", uart_state, 0);
    drive_bit(1'b1, bc);

    send_frame(8'hA3, 1'b0, -1);
    drive_bit(1'b1, bc);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 0);
    drive_bit(1'b1, bc);
    send_frame(8'h07, 1'b1, 1);
    drive_bit(1'b1, bc);
`endif

    for (int k = 0; k < 4; k++) begin
      baud_set = 3'(3 + $urandom % 2);
      bc = bit_clks(int'(baud_set));
      rb = 8'($urandom);
      rs = ($urandom % 4) != 0;
      pf = (($urandom % 3) == 0) ? int'($urandom % 2) : -1;
      send_frame(rb, rs, pf);
      if (!rs) drive_bit(1'b1, bc);
      else     drive_bit(1'b1, int'($urandom_range(0, bc)));
    end
    drive_bit(1'b1, bc);

    // Rate change mid-frame: that frame is don't-care, the next must be clean
    baud_set = 3'd4;
    bc = bit_clks(4);
    ignore_pulses = 1'b1;
    rb = 8'($urandom);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) baud_set = 3'd3;
      drive_bit(rb[i], bc);
    end
    if (PAR_EN != 0) drive_bit(^rb, bc);
    drive_bit(1'b1, bc);
    for (int i = 0; i < 20000 && uart_state; i++) @(negedge clk);
    check("rate_change_settles", uart_state, 0);
    bc = bit_clks(3);
    drive_bit(1'b1, bc);
    ignore_pulses = 1'b0;
    rb = 8'($urandom);
    send_frame(rb, 1'b1, -1);
    drive_bit(1'b1, bc);

    // Back-to-back at 9600, no idle gap
    baud_set = 3'd0;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    drive_bit(1'b1, bit_clks(4));

    // Reset while receiving D4
    baud_set = 3'd4;
    bc = bit_clks(4);
    drive_bit(1'b1, bc);
    ab = 8'hE6;
    drive_bit(1'b0, bc);
    for (int i = 0; i < 4; i++) drive_bit(ab[i], bc);
    rs232_rx = ab[4];
    repeat (bc / 2) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    check("midframe_reset_data_byte", data_byte, 8'h00);
    check("midframe_reset_uart_state", uart_state, 0);
    rs232_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2 * bc) @(negedge clk);
    check("post_reset_stays_idle", uart_state, 0);
    send_frame(8'h81, 1'b1, -1);
    drive_bit(1'b1, bc);

    for (int i = 0; i < 20000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("final_data_byte", data_byte, 8'h81);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
